// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Size code 3 is treated as a word access.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// 8-bit ready-handshaked data-memory port between the LSU and byte memory.
interface lsu_mem_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [7:0]        mem_rdata_i;
  logic              mem_ready_i;

  modport master (
    output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport slave (
    input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of the assembled load lanes to a 32-bit result.
module lsu_load_extend (
  input  logic [31:0] raw_i,
  input  logic [2:0]  nbytes_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);
  always_comb begin
    data_o = raw_i;
    case (nbytes_i)
      3'd1:    data_o = {{24{signed_i & raw_i[7]}},  raw_i[7:0]};
      3'd2:    data_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator: serialises a 32-bit load/store into little-endian
// byte transfers on the 8-bit memory port and stalls the pipeline meanwhile.
//
//   state  | meaning
//   IDLE   | no request pending; a request is latched and starts the access
//   ACCESS | byte k of the transaction is on the memory port
//   DONE   | one cycle; load result presented, stall released
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [31:0]       data_o,
  output logic              stall_o,
  lsu_mem_if.master         mem
);

  lsu_state_t        state_q;
  logic [1:0]        k_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lanes_q;
  logic [31:0]       lanes_d;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              mem_we_q;
  logic              mem_re_q;

  logic [2:0]  n_bytes;
  logic        last_byte;
  logic [1:0]  k_nxt;
  logic [31:0] ext_data;
  logic        req;

  assign req       = MemRead_i | MemWrite_i;
  assign n_bytes   = nbytes(size_q);
  assign last_byte = ({1'b0, k_q} == (n_bytes - 3'd1));
  assign k_nxt     = k_q + 2'd1;

  always_comb begin
    lanes_d = lanes_q;
    lanes_d[{k_q, 3'b000} +: 8] = mem.mem_rdata_i;
  end

  // Fed from lanes_d so the final byte lands in data_o on the DONE edge.
  lsu_load_extend u_ext (
    .raw_i    (lanes_d),
    .nbytes_i (n_bytes),
    .signed_i (signed_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      lanes_q     <= '0;
      data_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            size_q      <= size_i;
            signed_q    <= signed_i;
            wdata_q     <= data_i;
            lanes_q     <= '0;
            k_q         <= 2'd0;
            mem_addr_q  <= addr_i;
            mem_wdata_q <= data_i[7:0];
            mem_we_q    <= MemWrite_i;
            mem_re_q    <= ~MemWrite_i;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem.mem_ready_i) begin
            if (mem_re_q) lanes_q <= lanes_d;
            if (last_byte) begin
              if (mem_re_q) data_q <= ext_data;
              mem_we_q <= 1'b0;
              mem_re_q <= 1'b0;
              k_q      <= 2'd0;
              state_q  <= DONE;
            end else begin
              k_q         <= k_nxt;
              mem_addr_q  <= mem_addr_q + 1'b1;
              mem_wdata_q <= wdata_q[{k_nxt, 3'b000} +: 8];
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o         = ((state_q == IDLE) && req) || (state_q == ACCESS);
  assign data_o          = data_q;
  assign mem.mem_addr_o  = mem_addr_q;
  assign mem.mem_wdata_o = mem_wdata_q;
  assign mem.mem_we_o    = mem_we_q;
  assign mem.mem_re_o    = mem_re_q;

endmodule
